// File: rtl/iir_biquad_mul_sequencer.sv
// IIR biquad section: sequences five taps through one shared sign-magnitude multiplier.
// Optional IIR_SAT_EN: clamp output magnitude to 127 and flag ovf instead of wrapping.
module iir_biquad_mul_sequencer #(
    parameter int unsigned ACC_W = 36,
    parameter int unsigned SHIFT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  sample_in,
    input  logic        coef_we,
    input  logic [2:0]  coef_addr,
    input  logic [7:0]  coef_data,
    output logic [6:0]  mul_a,
    output logic [6:0]  mul_b,
    output logic        mul_sign_a,
    output logic        mul_sign_b,
    input  logic [31:0] mul_out,
    input  logic        mul_sign,
    input  logic        mul_ovf,
    output logic        busy,
    output logic        done,
    output logic [7:0]  y_out,
    output logic        ovf
);
    localparam int unsigned NTAPS = 5;
    localparam int unsigned MAG_W = 7;
    localparam int unsigned SM_W  = 8;
    localparam int unsigned K_W   = 3;
    localparam logic [K_W-1:0] LAST_TAP = K_W'(NTAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_SCALE,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [K_W-1:0]           r_k;
    logic [SM_W-1:0]          r_coef [NTAPS];
    logic [SM_W-1:0]          r_x0;
    logic [SM_W-1:0]          r_x1;
    logic [SM_W-1:0]          r_x2;
    logic [SM_W-1:0]          r_y1;
    logic [SM_W-1:0]          r_y2;
    logic signed [ACC_W-1:0]  r_acc;
    logic [SM_W-1:0]          r_y_out;
    logic                     r_done;
    logic                     r_busy;
    logic                     r_ovf;
    logic [MAG_W-1:0]         r_mul_a;
    logic [MAG_W-1:0]         r_mul_b;
    logic                     r_mul_sign_a;
    logic                     r_mul_sign_b;

    logic                     w_tap_load;
    logic [K_W-1:0]           w_tap_idx;
    logic [SM_W-1:0]          w_tap_coef;
    logic [SM_W-1:0]          w_tap_data;
    logic                     w_tap_fb;
    logic signed [ACC_W-1:0]  w_prod;
    logic [ACC_W-1:0]         w_acc_abs;
    logic [ACC_W-1:0]         w_mag_full;
    logic [MAG_W-1:0]         w_out_mag;
    logic                     w_out_neg;
    logic                     w_clamp;

    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_sign_a = r_mul_sign_a;
    assign mul_sign_b = r_mul_sign_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign y_out      = r_y_out;
    assign ovf        = r_ovf;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; also decides which tap's operands are staged for the next cycle
    always_comb begin
        w_state_nxt = r_state;
        w_tap_load  = 1'b0;
        w_tap_idx   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_MAC;
                w_tap_load  = 1'b1;
            end
            S_MAC: begin
                if (r_k == LAST_TAP) begin
                    w_state_nxt = S_SCALE;
                end else begin
                    w_tap_load = 1'b1;
                    w_tap_idx  = r_k + K_W'(1);
                end
            end
            S_SCALE: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tap operand mux: feedforward x0..x2, then negated feedback y1, y2
    always_comb begin
        w_tap_coef = '0;
        w_tap_data = '0;
        w_tap_fb   = 1'b0;
        case (w_tap_idx)
            3'd0: begin
                w_tap_coef = r_coef[0];
                w_tap_data = r_x0;
            end
            3'd1: begin
                w_tap_coef = r_coef[1];
                w_tap_data = r_x1;
            end
            3'd2: begin
                w_tap_coef = r_coef[2];
                w_tap_data = r_x2;
            end
            3'd3: begin
                w_tap_coef = r_coef[3];
                w_tap_data = r_y1;
                w_tap_fb   = 1'b1;
            end
            3'd4: begin
                w_tap_coef = r_coef[4];
                w_tap_data = r_y2;
                w_tap_fb   = 1'b1;
            end
            default: begin
                w_tap_coef = '0;
                w_tap_data = '0;
                w_tap_fb   = 1'b0;
            end
        endcase
    end

    assign w_prod     = mul_sign ? -$signed(ACC_W'(mul_out)) : $signed(ACC_W'(mul_out));
    assign w_acc_abs  = r_acc[ACC_W-1] ? $unsigned(-r_acc) : $unsigned(r_acc);
    assign w_mag_full = w_acc_abs >> SHIFT;

`ifdef IIR_SAT_EN
    logic w_big;
    assign w_big     = |w_mag_full[ACC_W-1:MAG_W];
    assign w_out_mag = w_big ? '1 : w_mag_full[MAG_W-1:0];
    assign w_clamp   = w_big;
`else
    logic w_unused_mag_hi;
    assign w_unused_mag_hi = ^w_mag_full[ACC_W-1:MAG_W];
    assign w_out_mag       = w_mag_full[MAG_W-1:0];
    assign w_clamp         = 1'b0;
`endif

    // A zero magnitude is always reported positive
    assign w_out_neg = r_acc[ACC_W-1] && (w_out_mag != '0);

    // Datapath, coefficient bank and delay lines
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k          <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                r_coef[i] <= '0;
            end
            r_x0         <= '0;
            r_x1         <= '0;
            r_x2         <= '0;
            r_y1         <= '0;
            r_y2         <= '0;
            r_acc        <= '0;
            r_y_out      <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_ovf        <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_sign_a <= 1'b0;
            r_mul_sign_b <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= 1'b0;
            if (w_tap_load) begin
                r_k          <= w_tap_idx;
                r_mul_a      <= w_tap_coef[MAG_W-1:0];
                r_mul_sign_a <= w_tap_coef[SM_W-1];
                r_mul_b      <= w_tap_data[MAG_W-1:0];
                r_mul_sign_b <= w_tap_data[SM_W-1] ^ w_tap_fb;
            end else begin
                r_mul_a      <= '0;
                r_mul_sign_a <= 1'b0;
                r_mul_b      <= '0;
                r_mul_sign_b <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (coef_we && (coef_addr < K_W'(NTAPS))) begin
                        r_coef[coef_addr] <= coef_data;
                    end
                    if (start) begin
                        r_x0  <= sample_in;
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod;
                    r_ovf <= r_ovf | mul_ovf;
                end
                S_SCALE: begin
                    r_y_out <= {w_out_neg, w_out_mag};
                    r_done  <= 1'b1;
                    r_ovf   <= r_ovf | w_clamp;
                end
                S_DONE: begin
                    r_x2 <= r_x1;
                    r_x1 <= r_x0;
                    r_y2 <= r_y1;
                    r_y1 <= r_y_out;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_mul_sequencer.sv
// Self-checking bench for iir_biquad_mul_sequencer: vector table, corner sequences, random vs model.
module tb_iir_biquad_mul_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, coef_we;
    logic [7:0]  sample_in, coef_data;
    logic [2:0]  coef_addr;
    logic [6:0]  mul_a, mul_b;
    logic        mul_sign_a, mul_sign_b;
    logic [31:0] mul_out;
    logic        mul_sign, mul_ovf;
    logic        busy, done, ovf;
    logic [7:0]  y_out;
    logic        force_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared multiplier
    assign mul_out  = 32'(mul_a) * 32'(mul_b);
    assign mul_sign = mul_sign_a ^ mul_sign_b;
    assign mul_ovf  = force_ovf;

    iir_biquad_mul_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .sample_in(sample_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_sign_a(mul_sign_a), .mul_sign_b(mul_sign_b),
        .mul_out(mul_out), .mul_sign(mul_sign), .mul_ovf(mul_ovf),
        .busy(busy), .done(done), .y_out(y_out), .ovf(ovf)
    );

    // Reference model: difference equation on plain integers
    int m_coef [5];
    int m_x1, m_x2, m_y1, m_y2;

    function automatic int sm2int(input logic [7:0] v);
        return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
    endfunction

    function automatic logic [8:0] model_eval(input int x0);
        int acc;
        int mag;
        logic [6:0] om;
        logic o;
        acc = m_coef[0]*x0 + m_coef[1]*m_x1 + m_coef[2]*m_x2 - m_coef[3]*m_y1 - m_coef[4]*m_y2;
        mag = ((acc < 0) ? -acc : acc) / 128;
        o   = 1'b0;
`ifdef IIR_SAT_EN
        if (mag > 127) begin
            mag = 127;
            o   = 1'b1;
        end
`endif
        om = 7'(mag);
        return {o, (acc < 0) && (om != 7'd0), om};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 5; i++) m_coef[i] = 0;
        m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int a, input logic [7:0] d);
        coef_we = 1'b1; coef_addr = 3'(a); coef_data = d;
        tick();
        coef_we = 1'b0;
        if (a < 5) m_coef[a] = sm2int(d);
    endtask

    task automatic write_all(input logic [7:0] b0, b1, b2, a1, a2);
        write_coef(0, b0); write_coef(1, b1); write_coef(2, b2);
        write_coef(3, a1); write_coef(4, a2);
    endtask

    // One full sample; returns DUT result and model prediction, checks timing
    task automatic run_sample(input string name, input logic [7:0] s,
                              output logic [7:0] y, output logic o,
                              output logic [7:0] my, output logic mo);
        int lat;
        logic [8:0] m;
        m  = model_eval(sm2int(s));
        my = m[7:0];
        mo = m[8];
        start = 1'b1; sample_in = s;
        tick();
        start = 1'b0; coef_we = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 20);
        check({name, " latency"}, lat, 7);
        y = y_out;
        o = ovf;
        tick();
        check({name, " done width"}, int'(done), 0);
        check({name, " busy after"}, int'(busy), 0);
        m_x2 = m_x1; m_x1 = sm2int(s);
        m_y2 = m_y1; m_y1 = sm2int(my);
    endtask

    typedef struct {
        string      name;
        bit         rst_first;
        logic [7:0] b0, b1, b2, a1, a2;
        logic [7:0] s;
        logic [7:0] exp_y;
        bit         exp_ovf;
    } vec_t;

    vec_t vt [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] y, my;
        logic o, mo;
        int nb, nd, lat;

        rst = 1'b0; start = 1'b0; coef_we = 1'b0; force_ovf = 1'b0;
        sample_in = '0; coef_addr = '0; coef_data = '0;
        model_clear();

        vt[0] = '{"b0=127 x=100",  1'b1, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h64, 8'h63, 1'b0};
        vt[1] = '{"fb x=100",      1'b1, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 8'h64, 8'h32, 1'b0};
        vt[2] = '{"fb x=0",        1'b0, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h99, 1'b0};
        vt[3] = '{"big s1",        1'b1, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h7F, 8'h7E, 1'b0};
`ifdef IIR_SAT_EN
        vt[4] = '{"big s2",        1'b0, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h7F, 8'h7F, 1'b1};
        vt[5] = '{"big s3",        1'b0, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h7F, 8'h7F, 1'b1};
`else
        vt[4] = '{"big s2",        1'b0, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h7F, 8'h7C, 1'b0};
        vt[5] = '{"big s3",        1'b0, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h7F, 8'h7A, 1'b0};
`endif
        vt[6] = '{"neg zero in",   1'b1, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0};
        vt[7] = '{"neg coef",      1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h64, 8'hE3, 1'b0};
        vt[8] = '{"neg trunc 0",   1'b1, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 1'b0};

        // Reset state
        do_reset();
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst y_out", int'(y_out), 0);
        check("rst ovf", int'(ovf), 0);
        check("rst mul_a", int'({mul_sign_a, mul_a}), 0);
        check("rst mul_b", int'({mul_sign_b, mul_b}), 0);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            if (vt[i].rst_first) do_reset();
            write_all(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].a1, vt[i].a2);
            run_sample(vt[i].name, vt[i].s, y, o, my, mo);
            check({vt[i].name, " y_out"}, int'(y), int'(vt[i].exp_y));
            check({vt[i].name, " ovf"}, int'(o), int'(vt[i].exp_ovf));
        end

        // Reset in the middle of MAC aborts and clears the delay lines
        do_reset();
        write_all(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00);
        run_sample("abort prime", 8'h64, y, o, my, mo);
        check("abort prime y_out", int'(y), 8'h63);
        start = 1'b1; sample_in = 8'h64;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check("abort busy", int'(busy), 0);
        check("abort y_out", int'(y_out), 0);
        nd = 0;
        repeat (12) begin
            tick();
            if (done) nd++;
        end
        check("abort no done", nd, 0);
        write_all(8'h00, 8'h7F, 8'h00, 8'h00, 8'h00);
        run_sample("abort hist", 8'h00, y, o, my, mo);
        check("abort hist y_out", int'(y), 0);

        // start/coef_we during busy are dropped
        do_reset();
        write_all(8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
        start = 1'b1; sample_in = 8'h64;
        tick();
        sample_in = 8'h10; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'h7F;
        nb = 0; nd = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (busy) nb++;
            if (done) nd++;
        end
        y = y_out;
        start = 1'b0; coef_we = 1'b0;
        check("busy full window", nb, 7);
        check("busy done at 7", nd, 1);
        check("busy y_out", int'(y), 8'h32);
        nd = 0;
        repeat (12) begin
            tick();
            if (done) nd++;
        end
        check("busy no second done", nd, 0);
        run_sample("busy coef kept", 8'h64, y, o, my, mo);
        check("busy coef kept y_out", int'(y), 8'h32);

        // start and coef_we in the same IDLE cycle: write seen by this sample
        do_reset();
        write_all(8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'h7F;
        m_coef[0] = 127;
        run_sample("same-cycle wr", 8'h64, y, o, my, mo);
        check("same-cycle wr y_out", int'(y), 8'h63);

        // Multiplier overflow on tap 2 is sticky, then cleared by the next start
        do_reset();
        write_all(8'h40, 8'h00, 8'h00, 8'h40, 8'h00);
        start = 1'b1; sample_in = 8'h64;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        force_ovf = 1'b1;
        tick();
        force_ovf = 1'b0;
        lat = 4;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("mulovf latency", lat, 7);
        check("mulovf ovf", int'(ovf), 1);
        check("mulovf y_out", int'(y_out), 8'h32);
        tick();
        start = 1'b1; sample_in = 8'h00;
        tick();
        start = 1'b0;
        check("mulovf cleared on start", int'(ovf), 0);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("mulovf next ovf", int'(ovf), 0);
        check("mulovf next y_out", int'(y_out), 8'h99);
        tick();

        // Random coefficients and samples against the model
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 0) begin
                write_all(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end
            run_sample("rand", 8'($urandom), y, o, my, mo);
            check($sformatf("rand %0d y_out", n), int'(y), int'(my));
            check($sformatf("rand %0d ovf", n), int'(o), int'(mo));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
